// File: rtl/b2b_router_pkg.sv
// Shared types and helpers for the board-to-board multicast router.
// FLAG_BIT matches the default 65-bit word; the router derives its own from DATA_WIDTH.
package b2b_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH = 65;
  localparam int FLAG_BIT = DEFAULT_DATA_WIDTH - 1;

  // Counters up to 64 bits share one helper; max_value is the counter's all-ones value.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max_value);
    return (value >= max_value) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/b2b_multicast_router_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or after ptr, wrapping.
// Produces a one-hot grant, its index and a valid flag.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!valid && req[idx]) begin
        valid      = 1'b1;
        grant_idx  = IDX_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/b2b_multicast_router.sv
// Drains whole events from cluster FIFOs and writes each one to every output board
// selected by the header's destination mask; zero-mask events are drained silently.
module b2b_multicast_router
  import b2b_router_pkg::*;
#(
  parameter int DATA_WIDTH          = 65,
  parameter int TOTAL_CLUSTERS      = 4,
  parameter int TOTAL_OUTPUT_BOARDS = 14,
  parameter int MASK_LSB            = 0,
  parameter int CNT_WIDTH           = 32
) (
  input  logic                                           clock,
  input  logic                                           reset,
  input  logic [TOTAL_CLUSTERS-1:0][DATA_WIDTH-1:0]      cluster_data,
  input  logic [TOTAL_CLUSTERS-1:0]                      cluster_empty,
  output logic [TOTAL_CLUSTERS-1:0]                      cluster_req,
  output logic [TOTAL_OUTPUT_BOARDS-1:0][DATA_WIDTH-1:0] output_board_event,
  output logic [TOTAL_OUTPUT_BOARDS-1:0]                 output_board_wren,
  input  logic [TOTAL_OUTPUT_BOARDS-1:0]                 output_board_almost_full,
  output logic                                           busy,
  output logic [CNT_WIDTH-1:0]                           events_forwarded,
  output logic [CNT_WIDTH-1:0]                           events_dropped,
  output logic [CNT_WIDTH-1:0]                           framing_errors
);

  localparam int IDX_W    = (TOTAL_CLUSTERS > 1) ? $clog2(TOTAL_CLUSTERS) : 1;
  localparam int FLAG_POS = DATA_WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TOTAL_CLUSTERS - 1);
  localparam logic [63:0] CNT_MAX = 64'({CNT_WIDTH{1'b1}});

  state_t                         state_reg, state_next;
  logic [IDX_W-1:0]               rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]               grant_reg, grant_next;
  logic [TOTAL_OUTPUT_BOARDS-1:0] mask_reg, mask_next;
  logic                           first_reg, first_next;
  logic [DATA_WIDTH-1:0]          event_reg;
  logic [TOTAL_OUTPUT_BOARDS-1:0] wren_reg;
  logic [CNT_WIDTH-1:0]           fwd_cnt_reg, drop_cnt_reg, frame_cnt_reg;

  logic [TOTAL_CLUSTERS-1:0]      arb_onehot;
  logic [IDX_W-1:0]               arb_idx;
  logic                           arb_valid;
  logic [DATA_WIDTH-1:0]          cand_word, head_word;
  logic [TOTAL_OUTPUT_BOARDS-1:0] cand_mask;
  logic [IDX_W-1:0]               ptr_after_grant;
  logic                           head_is_footer;
  logic                           wr_en, fwd_inc, drop_inc, frame_inc;

  rr_arbiter #(
    .N     (TOTAL_CLUSTERS),
    .IDX_W (IDX_W)
  ) u_arb (
    .req       (~cluster_empty),
    .ptr       (rr_ptr_reg),
    .grant     (arb_onehot),
    .grant_idx (arb_idx),
    .valid     (arb_valid)
  );

  assign cand_word       = cluster_data[arb_idx];
  assign cand_mask       = cand_word[MASK_LSB +: TOTAL_OUTPUT_BOARDS];
  assign head_word       = cluster_data[grant_reg];
  // The header itself carries flag=1; only a later flagged word closes the event.
  assign head_is_footer  = head_word[FLAG_POS] && !first_reg;
  assign ptr_after_grant = (grant_reg == LAST_IDX) ? '0 : grant_reg + IDX_W'(1);

  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    grant_next  = grant_reg;
    mask_next   = mask_reg;
    first_next  = first_reg;
    cluster_req = '0;
    wr_en       = 1'b0;
    fwd_inc     = 1'b0;
    drop_inc    = 1'b0;
    frame_inc   = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (arb_valid) begin
          if (!cand_word[FLAG_POS]) begin
            cluster_req = arb_onehot;
            frame_inc   = 1'b1;
          end else begin
            grant_next = arb_idx;
            mask_next  = cand_mask;
            first_next = 1'b1;
            state_next = (cand_mask != '0) ? FWD : DROP;
          end
        end
      end
      FWD: begin
        if (!cluster_empty[grant_reg] && ((mask_reg & output_board_almost_full) == '0)) begin
          cluster_req[grant_reg] = 1'b1;
          wr_en                  = 1'b1;
          first_next             = 1'b0;
          if (head_is_footer) begin
            state_next  = IDLE;
            rr_ptr_next = ptr_after_grant;
            fwd_inc     = 1'b1;
          end
        end
      end
      DROP: begin
        if (!cluster_empty[grant_reg]) begin
          cluster_req[grant_reg] = 1'b1;
          first_next             = 1'b0;
          if (head_is_footer) begin
            state_next  = IDLE;
            rr_ptr_next = ptr_after_grant;
            drop_inc    = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      mask_reg      <= '0;
      first_reg     <= 1'b0;
      event_reg     <= '0;
      wren_reg      <= '0;
      fwd_cnt_reg   <= '0;
      drop_cnt_reg  <= '0;
      frame_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      grant_reg  <= grant_next;
      mask_reg   <= mask_next;
      first_reg  <= first_next;
      wren_reg   <= wr_en ? mask_reg : '0;
      if (wr_en) begin
        event_reg <= head_word;
      end
      if (fwd_inc) begin
        fwd_cnt_reg <= CNT_WIDTH'(sat_inc(64'(fwd_cnt_reg), CNT_MAX));
      end
      if (drop_inc) begin
        drop_cnt_reg <= CNT_WIDTH'(sat_inc(64'(drop_cnt_reg), CNT_MAX));
      end
      if (frame_inc) begin
        frame_cnt_reg <= CNT_WIDTH'(sat_inc(64'(frame_cnt_reg), CNT_MAX));
      end
    end
  end

  generate
    for (genvar gi = 0; gi < TOTAL_OUTPUT_BOARDS; gi++) begin : g_board
      assign output_board_event[gi] = event_reg;
    end
  endgenerate

  assign output_board_wren = wren_reg;
  assign busy              = (state_reg != IDLE);
  assign events_forwarded  = fwd_cnt_reg;
  assign events_dropped    = drop_cnt_reg;
  assign framing_errors    = frame_cnt_reg;

endmodule

// File: doc/b2b_multicast_router.md
# b2b_multicast_router

Parametrised board-to-board event router: drains events from TOTAL_CLUSTERS cluster FIFOs and writes each complete event to one or more of TOTAL_OUTPUT_BOARDS output-board FIFOs selected by a destination mask in the event header. It sits between the cluster FIFOs and the output-board FIFOs of the board-to-board stage. Compared with the single-destination switch it adds:
- multicast;
- event-atomic round-robin arbitration;
- all-destination backpressure;
- drop of unroutable events;
- status counters.

## Interface
- DATA_WIDTH, 65: word width including metadata flag at bit DATA_WIDTH-1.
- TOTAL_CLUSTERS, 4: number of input cluster FIFOs (≥1).
- TOTAL_OUTPUT_BOARDS, 14: number of output board FIFOs (≤ DATA_WIDTH-1-MASK_LSB).
- MASK_LSB, 0: LSB of the destination mask field in the header word.
- CNT_WIDTH, 32: width of status counters.

Ports:
- clock  in  1  single clock, nominally 200 MHz.
- reset  in  1  asynchronous, active-high.
- cluster_data  in  [TOTAL_CLUSTERS][DATA_WIDTH]  FWFT head word of each cluster FIFO.
- cluster_empty  in  [TOTAL_CLUSTERS]  cluster FIFO empty.
- cluster_req  out  [TOTAL_CLUSTERS]  pop strobe, combinational, at most one hot.
- output_board_event  out  [TOTAL_OUTPUT_BOARDS][DATA_WIDTH]  registered write data, same word to all boards.
- output_board_wren  out  [TOTAL_OUTPUT_BOARDS]  registered write enables.
- output_board_almost_full  in  [TOTAL_OUTPUT_BOARDS]  board FIFO almost full; must assert with ≥2 free words.
- busy  out  1  state ≠ IDLE.
- events_forwarded  out  CNT_WIDTH  completed forwarded events.
- events_dropped  out  CNT_WIDTH  events with zero mask.
- framing_errors  out  CNT_WIDTH  stray non-header words discarded in IDLE.

## Operation
Event framing:
- Header word: flag=1.
- Payload words: flag=0, zero or more.
- Footer word: first flag=1 word after the header.
- Destination mask = header[MASK_LSB +: TOTAL_OUTPUT_BOARDS].

States:
- IDLE:
  - Candidates: clusters with !empty.
  - Pick the first candidate at or after rr_ptr (wrapping).
  - If its head word has flag=0: pop it in the same cycle, framing_errors++, stay in IDLE, rr_ptr unchanged.
  - If the head word is a header: latch grant and mask, no pop; go to FWD if mask≠0, else DROP.
- FWD: pop in any cycle where cluster_empty[grant]=0 and (mask & almost_full)==0. Each popped word is written to every board with mask bit set, including header and footer. Popping the footer → IDLE, rr_ptr = grant+1 mod TOTAL_CLUSTERS, events_forwarded++.
- DROP: pop whenever not empty, with no board writes. Popping the footer → IDLE, rr_ptr advances, events_dropped++.

Other rules:
- A "first word" flag distinguishes the header pop from the footer; the header pop never terminates an event.
- Grant is never changed mid-event, and other clusters never pop while an event is in progress.
- Counters saturate at all-ones.

## Timing
- cluster_req is combinational from state, grant, empty and almost_full; the FIFO advances at the clock edge where req=1.
- Output is registered: a word popped in cycle n appears on output_board_event with wren in cycle n+1.
- Latency from header reaching the head of an idle, non-empty FIFO to its board write is 2 cycles (IDLE decision, then pop, then write).
- Throughput: 1 word/cycle in FWD and DROP.
- Backpressure: a rising almost_full on any masked board stops pops in that same cycle; at most one word is in flight.
- Between events, IDLE costs one bubble cycle.

Reset values (async assert; release is synchronous to clock):
- State IDLE, rr_ptr 0, grant 0, mask 0.
- cluster_req 0, output_board_wren 0, output_board_event 0.
- All counters 0, busy 0.
- A reset mid-event abandons the event; no partial footer is emitted.

## Structure
- Package b2b_router_pkg holds:
  - state enum (IDLE, FWD, DROP);
  - localparam FLAG_BIT = DATA_WIDTH-1;
  - a saturating-increment function.
- Sub-module rr_arbiter (N requests, pointer input → one-hot grant plus index) is instantiated once.
- The remainder is flat in b2b_multicast_router.

## Test plan
- Unicast: cluster 0 holds header mask=0x0004, 3 payload words, footer → board 2 gets 5 words in order from cycle +2; events_forwarded=1; no other wren.
- Multicast: header mask=0x2001 → boards 0 and 13 receive identical 5-word streams in the same cycles.
- Round-robin: clusters 0–3 each hold one event to board 1 → board 1 order is cluster 0,1,2,3, events not interleaved; a second pass after refill starts at cluster 0.
- Backpressure: mask=0x0006 and board 2 almost_full held 10 cycles mid-event → no pops and no wren during the hold; resumes with no word lost or duplicated.
- Drop/framing: header mask=0 with 2 payload words → FIFO drained, events_dropped=1, no wren. A stray flag=0 word at head in IDLE → framing_errors=1.
- Reset mid-event: assert reset after 2 words → all outputs 0 immediately; after release, the next header routes normally.
